videogen_clut: RTL and testbench

// - Parametrised palette video generator: pixel index + bank -> RGB through an internal, CPU-writable CLUT RAM.
// - Sits between the tile/sprite mixer and the DAC. Supersedes fixed-PROM colour lookup.
// - Adds blanking, fixed-latency sync alignment, a 4-level fade and a palette write handshake.

---
 rtl/videogen_pkg.sv | 10 +
 rtl/clut_ram.sv | 18 +
 rtl/videogen_clut.sv | 74 +++++++
 tb/tb_videogen_clut.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/videogen_pkg.sv
// videogen_pkg: shared constants and packed-word helpers for the palette video generator
package videogen_pkg;
  localparam int LATENCY = 3;
  localparam int WR_POLICY_BLANK = 0;
  localparam int WR_POLICY_IMMEDIATE = 1;
  typedef enum int {COMP_R = 0, COMP_G = 1, COMP_B = 2} comp_e;
  function automatic int comp_lsb(input int cw, input comp_e c);
    return int'(c) * cw;
  endfunction
endpackage

// File: rtl/clut_ram.sv
// clut_ram: single-port palette RAM, synchronous read, write takes the port in its cycle
module clut_ram #(
  parameter int AW = 9,
  parameter int DW = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
    else rdata <= mem[raddr];
endmodule

// File: rtl/videogen_clut.sv
// videogen_clut: 3-stage palette lookup with blanking, sync alignment, fade and palette write port
module videogen_clut
  import videogen_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int BANK_W = 1,
  parameter int COLOR_W = 4,
  parameter int WR_POLICY = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                      CLK_6MD,
  input  logic                      nCLR,
  input  logic [INDEX_W-1:0]        D,
  input  logic [BANK_W-1:0]         BANK,
  input  logic                      BLANK,
  input  logic                      SYNC_IN,
  input  logic [1:0]                FADE,
  output logic                      SYNC,
  output logic [COLOR_W-1:0]        RED,
  output logic [COLOR_W-1:0]        GREEN,
  output logic [COLOR_W-1:0]        BLUE,
  input  logic                      wr_req,
  input  logic [BANK_W+INDEX_W-1:0] wr_addr,
  input  logic [3*COLOR_W-1:0]      wr_data,
  output logic                      wr_ack
);
  localparam int AW = BANK_W + INDEX_W;
  localparam int DW = 3 * COLOR_W;
  localparam int RL = comp_lsb(COLOR_W, COMP_R);
  localparam int GL = comp_lsb(COLOR_W, COMP_G);
  localparam int BL = comp_lsb(COLOR_W, COMP_B);
  logic [AW-1:0] addr1;
  logic blank1, blank2, sync1, sync2;
  logic [1:0] fade1, fade2;
  logic [DW-1:0] rdata;
  logic we;
  // in blank-only mode the stolen read belongs to a blanked pixel, so the picture is untouched
  assign we = nCLR && wr_req && (WR_POLICY == WR_POLICY_IMMEDIATE || blank1);
  assign wr_ack = we;
  clut_ram #(.AW(AW), .DW(DW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(CLK_6MD),
    .we(we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(addr1),
    .rdata(rdata)
  );
  always_ff @(posedge CLK_6MD)
    if (!nCLR) begin
      addr1 <= '0;
      blank1 <= 1'b1;
      blank2 <= 1'b1;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fade1 <= '0;
      fade2 <= '0;
      SYNC <= 1'b0;
      RED <= '0;
      GREEN <= '0;
      BLUE <= '0;
    end else begin
      addr1 <= {BANK, D};
      blank1 <= BLANK;
      sync1 <= SYNC_IN;
      fade1 <= FADE;
      blank2 <= blank1;
      sync2 <= sync1;
      fade2 <= fade1;
      SYNC <= sync2;
      RED <= blank2 ? '0 : rdata[RL +: COLOR_W] >> fade2;
      GREEN <= blank2 ? '0 : rdata[GL +: COLOR_W] >> fade2;
      BLUE <= blank2 ? '0 : rdata[BL +: COLOR_W] >> fade2;
    end
endmodule

// File: tb/tb_videogen_clut.sv
// tb_videogen_clut: directed checks of lookup, fade, blank, sync delay and both write policies
module tb_videogen_clut;
  import videogen_pkg::*;
  logic clk = 1'b0;
  logic nclr;
  logic [7:0] d;
  logic bank;
  logic blank, sync_in;
  logic [1:0] fade;
  logic wr_req0, wr_req1;
  logic [8:0] wr_addr0, wr_addr1;
  logic [11:0] wr_data0, wr_data1;
  logic sync0, sync1, wr_ack0, wr_ack1;
  logic [3:0] red0, green0, blue0, red1, green1, blue1;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  videogen_clut #(.WR_POLICY(0)) u0 (
    .CLK_6MD(clk), .nCLR(nclr), .D(d), .BANK(bank), .BLANK(blank), .SYNC_IN(sync_in), .FADE(fade),
    .SYNC(sync0), .RED(red0), .GREEN(green0), .BLUE(blue0),
    .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ack(wr_ack0)
  );
  videogen_clut #(.WR_POLICY(1)) u1 (
    .CLK_6MD(clk), .nCLR(nclr), .D(d), .BANK(bank), .BLANK(blank), .SYNC_IN(sync_in), .FADE(fade),
    .SYNC(sync1), .RED(red1), .GREEN(green1), .BLUE(blue1),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ack(wr_ack1)
  );

  task automatic look(input logic b, input logic [7:0] idx, input logic [1:0] f, input logic bl);
    bank = b;
    d = idx;
    fade = f;
    blank = bl;
    repeat (LATENCY) @(negedge clk);
  endtask

  task automatic write_entry(input bit sel, input logic [8:0] a, input logic [11:0] v);
    bit got = 0;
    if (sel) begin wr_req1 = 1'b1; wr_addr1 = a; wr_data1 = v; end
    else begin wr_req0 = 1'b1; wr_addr0 = a; wr_data0 = v; end
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = sel ? wr_ack1 : wr_ack0;
      @(negedge clk);
    end
    wr_req0 = 1'b0;
    wr_req1 = 1'b0;
    total++;
    if (!got) $display("FAIL write_timeout dut%0d addr=%h: ack=0 required=1", sel, a);
    else passed++;
  endtask

  task automatic test_reset();
    nclr = 1'b0;
    d = 8'hFF;
    bank = 1'b0;
    blank = 1'b0;
    sync_in = 1'b0;
    fade = 2'd0;
    wr_req0 = 1'b0;
    wr_req1 = 1'b0;
    wr_addr0 = '0;
    wr_addr1 = '0;
    wr_data0 = '0;
    wr_data1 = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({sync0, wr_ack0, blue0, green0, red0, sync1, wr_ack1, blue1, green1, red1} !== 28'h0)
        $display("FAIL reset_hold cyc%0d: got %h required 0", i,
                 {sync0, wr_ack0, blue0, green0, red0, sync1, wr_ack1, blue1, green1, red1});
      else passed++;
    end
    nclr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({sync0, wr_ack0, blue0, green0, red0, sync1, wr_ack1, blue1, green1, red1} !== 28'h0)
        $display("FAIL reset_release cyc%0d: got %h required 0", i,
                 {sync0, wr_ack0, blue0, green0, red0, sync1, wr_ack1, blue1, green1, red1});
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic preload();
    blank = 1'b1;
    repeat (2) @(negedge clk);
    write_entry(0, 9'h1A5, 12'h3C7);
    write_entry(1, 9'h1A5, 12'h3C7);
    write_entry(0, 9'h020, 12'h5A9);
    write_entry(1, 9'h020, 12'h5A9);
  endtask

  task automatic test_lookup();
    look(1'b1, 8'hA5, 2'd0, 1'b0);
    total++;
    if ({blue0, green0, red0} !== 12'h3C7) $display("FAIL lookup dut0: got %h required 3c7", {blue0, green0, red0});
    else passed++;
    total++;
    if ({blue1, green1, red1} !== 12'h3C7) $display("FAIL lookup dut1: got %h required 3c7", {blue1, green1, red1});
    else passed++;
  endtask

  task automatic test_fade_blank();
    logic [1:0] fades [3] = '{2'd1, 2'd2, 2'd3};
    logic [11:0] exps [3] = '{12'h163, 12'h031, 12'h010};
    for (int i = 0; i < 3; i++) begin
      look(1'b1, 8'hA5, fades[i], 1'b0);
      total++;
      if ({blue0, green0, red0} !== exps[i])
        $display("FAIL fade%0d: got %h required %h", fades[i], {blue0, green0, red0}, exps[i]);
      else passed++;
    end
    look(1'b1, 8'hA5, 2'd0, 1'b1);
    total++;
    if ({blue0, green0, red0, blue1, green1, red1} !== 24'h0)
      $display("FAIL blank: got %h required 0", {blue0, green0, red0, blue1, green1, red1});
    else passed++;
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if ({sync1, sync0} !== ((i == LATENCY) ? 2'b11 : 2'b00))
        $display("FAIL sync_delay cyc%0d: got %b required %b", i, {sync1, sync0}, (i == LATENCY) ? 2'b11 : 2'b00);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_policy0();
    look(1'b1, 8'hA5, 2'd0, 1'b0);
    wr_req0 = 1'b1;
    wr_addr0 = 9'h0C3;
    wr_data0 = 12'h8E4;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (wr_ack0 !== 1'b0) $display("FAIL p0_active_ack cyc%0d: got %b required 0", i, wr_ack0);
      else passed++;
      @(negedge clk);
    end
    blank = 1'b1;
    #1;
    total++;
    if (wr_ack0 !== 1'b0) $display("FAIL p0_blank_rise_ack: got %b required 0", wr_ack0);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (wr_ack0 !== 1'b1) $display("FAIL p0_commit_ack: got %b required 1", wr_ack0);
    else passed++;
    @(negedge clk);
    wr_req0 = 1'b0;
    #1;
    total++;
    if (wr_ack0 !== 1'b0) $display("FAIL p0_ack_pulse: got %b required 0", wr_ack0);
    else passed++;
    look(1'b0, 8'hC3, 2'd0, 1'b0);
    total++;
    if ({blue0, green0, red0} !== 12'h8E4) $display("FAIL p0_readback: got %h required 8e4", {blue0, green0, red0});
    else passed++;
  endtask

  task automatic test_policy1();
    look(1'b0, 8'h20, 2'd0, 1'b0);
    d = 8'hA5;
    bank = 1'b1;
    @(negedge clk);
    d = 8'h10;
    bank = 1'b0;
    wr_req1 = 1'b1;
    wr_addr1 = 9'h010;
    wr_data1 = 12'hFFF;
    #1;
    total++;
    if (wr_ack1 !== 1'b1) $display("FAIL p1_immediate_ack: got %b required 1", wr_ack1);
    else passed++;
    @(negedge clk);
    wr_req1 = 1'b0;
    d = 8'h20;
    #1;
    total++;
    if ({wr_ack1, blue1, green1, red1} !== 13'h05A9)
      $display("FAIL p1_prev_pixel: got %h required 05a9", {wr_ack1, blue1, green1, red1});
    else passed++;
    @(negedge clk);
    total++;
    if ({blue1, green1, red1} !== 12'h5A9) $display("FAIL p1_stolen_repeat: got %h required 5a9", {blue1, green1, red1});
    else passed++;
    total++;
    if ({blue0, green0, red0} !== 12'h3C7) $display("FAIL p0_not_stolen: got %h required 3c7", {blue0, green0, red0});
    else passed++;
    @(negedge clk);
    total++;
    if ({blue1, green1, red1} !== 12'hFFF) $display("FAIL p1_new_data: got %h required fff", {blue1, green1, red1});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] addrs [4] = '{9'h100, 9'h1FF, 9'h000, 9'h0A5};
    logic [11:0] vals [4] = '{12'h111, 12'hABC, 12'h0F0, 12'hE1D};
    blank = 1'b1;
    repeat (2) @(negedge clk);
    wr_req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr0 = addrs[i];
      wr_data0 = vals[i];
      #1;
      total++;
      if (wr_ack0 !== 1'b1) $display("FAIL b2b_ack%0d: got %b required 1", i, wr_ack0);
      else passed++;
      @(negedge clk);
    end
    wr_req0 = 1'b0;
    #1;
    total++;
    if (wr_ack0 !== 1'b0) $display("FAIL b2b_ack_end: got %b required 0", wr_ack0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      look(addrs[i][8], addrs[i][7:0], 2'd0, 1'b0);
      total++;
      if ({blue0, green0, red0} !== vals[i])
        $display("FAIL b2b_readback %h: got %h required %h", addrs[i], {blue0, green0, red0}, vals[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_lookup();
    test_fade_blank();
    test_policy0();
    test_policy1();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
